// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM port arbiter.
package ram_arb_pkg;

    localparam int AW_DEF    = 6;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 64;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SERVE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer names the requester that wins a tie.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       ptr_clr,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[REQ0] && req[REQ1]) begin
                gnt[ptr_q] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // After a grant the other side gets priority; idle cycles leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_clr) begin
            ptr_d = 1'b0;
        end else if (gnt[REQ0]) begin
            ptr_d = 1'b1;
        end else if (gnt[REQ1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two requesters and owns
// its zero-initialisation sweep after reset or on a clear command.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_busy,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [AW:0] CLR_LAST = (AW + 1)'(DEPTH - 1);

    state_e        state_q;
    state_e        state_d;
    logic [AW:0]   clr_cnt_q;
    logic [AW:0]   clr_cnt_d;
    logic [AW-1:0] addr_hold_q;
    logic [1:0]    rsp_tag_q;
    logic [1:0]    rsp_tag_d;

    logic [1:0]    req_valid;
    logic [1:0]    gnt;
    logic          arb_en;
    logic          arb_ptr_clr;
    logic [DW-1:0] rsp_rdata [2];

    assign req_valid   = {req1_valid, req0_valid};
    assign arb_en      = (state_q == ST_SERVE);
    assign arb_ptr_clr = (state_q != ST_SERVE);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (arb_en),
        .ptr_clr (arb_ptr_clr),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[REQ0];
    assign req1_ready = gnt[REQ1];
    assign clr_busy   = (state_q != ST_SERVE);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rsp_tag_d = 2'b00;
        ram_we    = 1'b0;
        ram_addr  = addr_hold_q;
        ram_din   = '0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_cnt_q[AW-1:0];
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_SERVE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_SERVE: begin
                if (gnt[REQ0]) begin
                    ram_we          = req0_we;
                    ram_addr        = req0_addr;
                    ram_din         = req0_wdata;
                    rsp_tag_d[REQ0] = ~req0_we;
                end else if (gnt[REQ1]) begin
                    ram_we          = req1_we;
                    ram_addr        = req1_addr;
                    ram_din         = req1_wdata;
                    rsp_tag_d[REQ1] = ~req1_we;
                end
                // The grant above still lands on this edge; clearing starts next.
                if (clr_req) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            addr_hold_q <= '0;
            rsp_tag_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            addr_hold_q <= ram_addr;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    // Read data is the RAM output itself, forced to zero outside its response cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_rdata[gi] = rsp_tag_q[gi] ? ram_dout : '0;
    end

    assign rsp0_valid = rsp_tag_q[REQ0];
    assign rsp1_valid = rsp_tag_q[REQ1];
    assign rsp0_rdata = rsp_rdata[REQ0];
    assign rsp1_rdata = rsp_rdata[REQ1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, per-cycle reference model and directed scenarios.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_req;
    logic       clr_busy;
    logic       req0_valid, req0_ready, req0_we;
    logic [5:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       rsp0_valid;
    logic [7:0] rsp0_rdata;
    logic       req1_valid, req1_ready, req1_we;
    logic [5:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp1_valid;
    logic [7:0] rsp1_rdata;
    logic       ram_we;
    logic [5:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = 8'h00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // 64x8 synchronous RAM with registered read, pre-filled with 0xFF.
    logic       tb_fill;
    logic [7:0] ram_mem [64];
    always @(posedge clk) begin
        if (tb_fill) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= 8'hFF;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
        end
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: clr_left counts remaining busy cycles (65 = init cycle pending).
    int         clr_left = 65;
    logic       m_ptr = 1'b0;
    logic [1:0] m_pend = 2'b00;
    logic [7:0] m_pend_data = 8'h00;
    logic [5:0] m_last_addr = 6'd0;
    logic [7:0] m_mem [64];
    logic [1:0] m_gnt = 2'b00;
    logic       m_we = 1'b0;
    logic [5:0] m_addr = 6'd0;
    logic [7:0] m_din = 8'h00;

    always @(negedge clk) begin
        logic [1:0] g;
        logic       e_busy, e_we;
        logic [5:0] e_addr;
        logic [7:0] e_din;
        logic [1:0] e_rv;
        logic [7:0] e_rd0, e_rd1;
        g = 2'b00; e_we = 1'b0; e_din = 8'h00; e_addr = 6'd0;
        e_busy = 1'b1; e_rv = 2'b00; e_rd0 = 8'h00; e_rd1 = 8'h00;
        if (rst_n) begin
            e_busy = (clr_left > 0);
            e_rv   = m_pend;
            e_rd0  = m_pend[0] ? m_pend_data : 8'h00;
            e_rd1  = m_pend[1] ? m_pend_data : 8'h00;
            e_addr = m_last_addr;
            if (clr_left > 0 && clr_left <= 64) begin
                e_we   = 1'b1;
                e_addr = 6'(64 - clr_left);
            end else if (clr_left == 0) begin
                if (req0_valid && req1_valid) g = m_ptr ? 2'b10 : 2'b01;
                else g = {req1_valid, req0_valid};
                if (g[0]) begin
                    e_we = req0_we; e_addr = req0_addr; e_din = req0_wdata;
                end else if (g[1]) begin
                    e_we = req1_we; e_addr = req1_addr; e_din = req1_wdata;
                end
            end
        end
        m_gnt  <= g;
        m_we   <= e_we;
        m_addr <= e_addr;
        m_din  <= e_din;
        chk("clr_busy", clr_busy, e_busy);
        chk("req0_ready", req0_ready, g[0]);
        chk("req1_ready", req1_ready, g[1]);
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_din", ram_din, e_din);
        chk("rsp0_valid", rsp0_valid, e_rv[0]);
        chk("rsp1_valid", rsp1_valid, e_rv[1]);
        chk("rsp0_rdata", rsp0_rdata, e_rd0);
        chk("rsp1_rdata", rsp1_rdata, e_rd1);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_left    <= 65;
            m_ptr       <= 1'b0;
            m_pend      <= 2'b00;
            m_pend_data <= 8'h00;
            m_last_addr <= 6'd0;
            if (tb_fill) begin
                for (int i = 0; i < 64; i++) m_mem[i] <= 8'hFF;
            end
        end else begin
            m_last_addr <= m_addr;
            m_pend      <= 2'b00;
            if (clr_left > 0) begin
                if (clr_left <= 64) m_mem[64 - clr_left] <= 8'h00;
                clr_left <= clr_left - 1;
                if (clr_left == 1) m_ptr <= 1'b0;
            end else begin
                if (m_gnt != 2'b00) begin
                    m_ptr <= m_gnt[0];
                    if (m_we) begin
                        m_mem[m_addr] <= m_din;
                    end else begin
                        m_pend      <= m_gnt;
                        m_pend_data <= m_mem[m_addr];
                    end
                end
                if (clr_req) clr_left <= 64;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         n, n2;
        logic [7:0] gseq, rseq;
        logic       ready_seen, first_seen;
        logic [5:0] first_addr;

        tb_fill = 1'b1;
        rst_n = 1'b0; clr_req = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 6'd0; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 6'd0; req1_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tb_fill = 1'b0;
        rst_n = 1'b1;

        // Power-up clear: 1 INIT + 64 CLEAR cycles.
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (!clr_busy) break;
            n++;
        end
        chk("init_busy_cycles", n, 65);

        // Both requesters reading: grants and responses alternate 0,1,0,1.
        gseq = 8'h00; rseq = 8'h00;
        tick();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd1;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            gseq[2*k +: 2] = req1_ready ? 2'd1 : (req0_ready ? 2'd0 : 2'd2);
            if (k > 0) rseq[2*(k-1) +: 2] = rsp1_valid ? 2'd1 : (rsp0_valid ? 2'd0 : 2'd2);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rseq[7:6] = rsp1_valid ? 2'd1 : (rsp0_valid ? 2'd0 : 2'd2);
        chk("rr_grant_seq", gseq, 8'h44);
        chk("rr_rsp_seq", rseq, 8'h44);

        // Any cleared location reads zero.
        tick();
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd7;
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("cleared_rd_valid", rsp1_valid, 1'b1);
        chk("cleared_rd_data", rsp1_rdata, 8'h00);

        // Write then back-to-back read of the same address.
        tick();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'd5; req0_wdata = 8'hA5;
        tick();
        req0_we = 1'b0;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rsp0_valid", rsp0_valid, 1'b1);
        chk("b2b_rsp0_rdata", rsp0_rdata, 8'hA5);
        chk("b2b_rsp1_quiet", rsp1_valid, 1'b0);

        // clr_req during a read: response still arrives, then a full clear.
        tick();
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 6'd63; req1_wdata = 8'h3C;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd63; clr_req = 1'b1;
        tick();
        req0_valid = 1'b0; clr_req = 1'b0;
        @(negedge clk);
        chk("clr_rd_valid", rsp0_valid, 1'b1);
        chk("clr_rd_data", rsp0_rdata, 8'h3C);
        n = clr_busy ? 1 : 0;
        while (n > 0 && n < 300) begin
            @(negedge clk);
            if (!clr_busy) break;
            n++;
        end
        chk("cmd_clear_cycles", n, 64);
        tick();
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd63;
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("post_clr_valid", rsp1_valid, 1'b1);
        chk("post_clr_data", rsp1_rdata, 8'h00);

        // clr_req at clr_cnt=20 is ignored.
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (!clr_busy) break;
            n++;
            tick();
            clr_req = (n == 20);
        end
        clr_req = 1'b0;
        chk("ignored_clr_cycles", n, 64);

        // Reset at clr_cnt=30: restart from INIT with a pending request held.
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (!clr_busy) break;
            n++;
            tick();
            if (n == 30) begin
                rst_n = 1'b0;
                req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd9;
                tick();
                rst_n = 1'b1;
                break;
            end
        end
        chk("abort_point", n, 30);
        n2 = 0; ready_seen = 1'b0; first_seen = 1'b0; first_addr = 6'h3F;
        while (n2 < 300) begin
            @(negedge clk);
            if (!clr_busy) break;
            n2++;
            ready_seen = ready_seen | req0_ready | req1_ready;
            if (ram_we && !first_seen) begin
                first_seen = 1'b1;
                first_addr = ram_addr;
            end
        end
        chk("restart_busy_cycles", n2, 65);
        chk("restart_first_addr", first_addr, 6'd0);
        chk("ready_low_in_clear", ready_seen, 1'b0);
        chk("held_req_granted", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("held_req_rsp_valid", rsp0_valid, 1'b1);
        chk("held_req_rsp_data", rsp0_rdata, 8'h00);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
